// File: rtl/wr_en_decoder_pipe.sv
// Dual-port registered write-enable decoder for the register file.
// Each port decodes to a one-hot enable; results are merged, masked and launched from flops.
module wr_en_decoder_pipe #(
    parameter int ADDR_W   = 5,
    parameter int ZERO_IDX = 31,
    parameter int PRIO1    = 1,
    localparam int N_OUT   = 2**ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall_i,
    input  logic              en0_i,
    input  logic [ADDR_W-1:0] addr0_i,
    input  logic              en1_i,
    input  logic [ADDR_W-1:0] addr1_i,
    output logic [N_OUT-1:0]  out_o,
    output logic [N_OUT-1:0]  sel1_o,
    output logic              conflict_o,
    output logic              valid_o
);

    // An out-of-range ZERO_IDX leaves every index writable.
    localparam logic [N_OUT-1:0] ZERO_MASK =
        (ZERO_IDX >= 0 && ZERO_IDX < N_OUT) ? (N_OUT'(1) << ZERO_IDX) : '0;

    logic [N_OUT-1:0] w_dec0;
    logic [N_OUT-1:0] w_dec1;
    logic [N_OUT-1:0] w_d0;
    logic [N_OUT-1:0] w_d1;
    logic [N_OUT-1:0] w_out;
    logic [N_OUT-1:0] w_sel1;
    logic             w_conflict;
    logic             w_valid;

    logic [N_OUT-1:0] r_out;
    logic [N_OUT-1:0] r_sel1;
    logic             r_conflict;
    logic             r_valid;

    always_comb begin
        w_dec0 = en0_i ? (N_OUT'(1) << addr0_i) : '0;
        w_dec1 = en1_i ? (N_OUT'(1) << addr1_i) : '0;
        w_d0   = w_dec0 & ~ZERO_MASK;
        w_d1   = w_dec1 & ~ZERO_MASK;
        w_out  = w_d0 | w_d1;
        // Overlap of the masked one-hots only happens on a real same-index double write.
        w_conflict = |(w_d0 & w_d1);
        w_sel1     = (PRIO1 != 0) ? w_d1 : (w_d1 & ~w_d0);
        w_valid    = |w_out;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_out      <= '0;
            r_sel1     <= '0;
            r_conflict <= 1'b0;
            r_valid    <= 1'b0;
        end else if (!stall_i) begin
            r_out      <= w_out;
            r_sel1     <= w_sel1;
            r_conflict <= w_conflict;
            r_valid    <= w_valid;
        end
    end

    assign out_o      = r_out;
    assign sel1_o     = r_sel1;
    assign conflict_o = r_conflict;
    assign valid_o    = r_valid;

endmodule

// File: tb/tb_wr_en_decoder_pipe.sv
// Bench for wr_en_decoder_pipe: five parameter sets driven in lockstep, checked
// against an index-level model every cycle, plus literal expectations on directed steps.
module tb_wr_en_decoder_pipe;

    localparam int NI = 5;
    localparam int P_AW [NI] = '{5, 5, 5, 3, 6};
    localparam int P_ZI [NI] = '{31, 32, 31, 5, 0};
    localparam int P_PR [NI] = '{1, 1, 0, 1, 0};

    logic       clk = 1'b0;
    logic       t_rst = 1'b1;
    logic       t_stall = 1'b0;
    logic       t_en0 = 1'b0;
    logic [7:0] t_a0 = '0;
    logic       t_en1 = 1'b0;
    logic [7:0] t_a1 = '0;

    logic [31:0] o0_out, o0_sel, o1_out, o1_sel, o2_out, o2_sel;
    logic [7:0]  o3_out, o3_sel;
    logic [63:0] o4_out, o4_sel;
    logic [NI-1:0] o_conf, o_val;

    logic [255:0] g_out [NI];
    logic [255:0] g_sel [NI];
    logic [255:0] m_out [NI];
    logic [255:0] m_sel [NI];
    logic         m_conf [NI];
    logic         m_val [NI];

    int  n_checks = 0;
    int  n_errors = 0;
    bit  chk_en = 1'b0;

    always #5 clk = ~clk;

    wr_en_decoder_pipe #(.ADDR_W(5), .ZERO_IDX(31), .PRIO1(1)) u0 (
        .clk(clk), .reset(t_rst), .stall_i(t_stall), .en0_i(t_en0), .addr0_i(t_a0[4:0]),
        .en1_i(t_en1), .addr1_i(t_a1[4:0]), .out_o(o0_out), .sel1_o(o0_sel),
        .conflict_o(o_conf[0]), .valid_o(o_val[0]));
    wr_en_decoder_pipe #(.ADDR_W(5), .ZERO_IDX(32), .PRIO1(1)) u1 (
        .clk(clk), .reset(t_rst), .stall_i(t_stall), .en0_i(t_en0), .addr0_i(t_a0[4:0]),
        .en1_i(t_en1), .addr1_i(t_a1[4:0]), .out_o(o1_out), .sel1_o(o1_sel),
        .conflict_o(o_conf[1]), .valid_o(o_val[1]));
    wr_en_decoder_pipe #(.ADDR_W(5), .ZERO_IDX(31), .PRIO1(0)) u2 (
        .clk(clk), .reset(t_rst), .stall_i(t_stall), .en0_i(t_en0), .addr0_i(t_a0[4:0]),
        .en1_i(t_en1), .addr1_i(t_a1[4:0]), .out_o(o2_out), .sel1_o(o2_sel),
        .conflict_o(o_conf[2]), .valid_o(o_val[2]));
    wr_en_decoder_pipe #(.ADDR_W(3), .ZERO_IDX(5), .PRIO1(1)) u3 (
        .clk(clk), .reset(t_rst), .stall_i(t_stall), .en0_i(t_en0), .addr0_i(t_a0[2:0]),
        .en1_i(t_en1), .addr1_i(t_a1[2:0]), .out_o(o3_out), .sel1_o(o3_sel),
        .conflict_o(o_conf[3]), .valid_o(o_val[3]));
    wr_en_decoder_pipe #(.ADDR_W(6), .ZERO_IDX(0), .PRIO1(0)) u4 (
        .clk(clk), .reset(t_rst), .stall_i(t_stall), .en0_i(t_en0), .addr0_i(t_a0[5:0]),
        .en1_i(t_en1), .addr1_i(t_a1[5:0]), .out_o(o4_out), .sel1_o(o4_sel),
        .conflict_o(o_conf[4]), .valid_o(o_val[4]));

    assign g_out[0] = 256'(o0_out);
    assign g_sel[0] = 256'(o0_sel);
    assign g_out[1] = 256'(o1_out);
    assign g_sel[1] = 256'(o1_sel);
    assign g_out[2] = 256'(o2_out);
    assign g_sel[2] = 256'(o2_sel);
    assign g_out[3] = 256'(o3_out);
    assign g_sel[3] = 256'(o3_sel);
    assign g_out[4] = 256'(o4_out);
    assign g_sel[4] = 256'(o4_sel);

    // Reference: work with destination indices, then build the vectors.
    always @(posedge clk) begin
        for (int i = 0; i < NI; i++) begin
            int  a0, a1;
            bit  v0, v1, same;
            if (t_rst) begin
                m_out[i] = '0; m_sel[i] = '0; m_conf[i] = 1'b0; m_val[i] = 1'b0;
            end else if (!t_stall) begin
                a0 = int'(t_a0) % (1 << P_AW[i]);
                a1 = int'(t_a1) % (1 << P_AW[i]);
                v0 = t_en0 && (a0 != P_ZI[i]);
                v1 = t_en1 && (a1 != P_ZI[i]);
                same = v0 && v1 && (a0 == a1);
                m_out[i] = '0;
                m_sel[i] = '0;
                if (v0) m_out[i][a0] = 1'b1;
                if (v1) m_out[i][a1] = 1'b1;
                if (v1 && (P_PR[i] == 1 || !same)) m_sel[i][a1] = 1'b1;
                m_conf[i] = same;
                m_val[i]  = v0 || v1;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < NI; i++) begin
                n_checks += 7;
                if (g_out[i] !== m_out[i]) begin
                    n_errors++;
                    $display("FAIL model_out[%0d] got %h want %h", i, g_out[i], m_out[i]);
                end
                if (g_sel[i] !== m_sel[i]) begin
                    n_errors++;
                    $display("FAIL model_sel1[%0d] got %h want %h", i, g_sel[i], m_sel[i]);
                end
                if (o_conf[i] !== m_conf[i]) begin
                    n_errors++;
                    $display("FAIL model_conflict[%0d] got %b want %b", i, o_conf[i], m_conf[i]);
                end
                if (o_val[i] !== m_val[i]) begin
                    n_errors++;
                    $display("FAIL model_valid[%0d] got %b want %b", i, o_val[i], m_val[i]);
                end
                if ($countones(g_out[i]) > 2) begin
                    n_errors++;
                    $display("FAIL inv_popcount[%0d] got %0d want <=2", i, $countones(g_out[i]));
                end
                if ((g_sel[i] & ~g_out[i]) != '0) begin
                    n_errors++;
                    $display("FAIL inv_sel_subset[%0d] got sel %h out %h", i, g_sel[i], g_out[i]);
                end
                if (o_conf[i] === 1'b1 && $countones(g_out[i]) != 1) begin
                    n_errors++;
                    $display("FAIL inv_conflict_pop[%0d] got %0d want 1", i, $countones(g_out[i]));
                end
            end
        end
    end

    task automatic step(input bit r, input bit s, input bit e0, input int a0,
                        input bit e1, input int a1);
        @(negedge clk);
        t_rst = r; t_stall = s; t_en0 = e0; t_a0 = 8'(a0); t_en1 = e1; t_a1 = 8'(a1);
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %h want %h", nm, got, exp);
        end
    endtask

    initial begin
        step(1, 0, 1, 3, 0, 0);
        chk_en = 1'b1;
        chk("rst_out", g_out[0], 256'h0);
        step(1, 0, 1, 3, 0, 0);
        chk("rst_out2", g_out[0], 256'h0);
        chk("rst_valid", 256'(o_val[0]), 256'h0);
        step(0, 0, 1, 3, 0, 0);
        chk("first_out", g_out[0], 256'h8);
        chk("first_valid", 256'(o_val[0]), 256'h1);

        for (int a = 0; a < 32; a++) begin
            step(0, 0, 1, a, 0, 0);
            chk("sweep_out", g_out[0], (a == 31) ? 256'h0 : (256'h1 << a));
            chk("sweep_sel", g_sel[0], 256'h0);
            chk("sweep_nomask_out", g_out[1], 256'h1 << a);
        end
        chk("addr31_valid", 256'(o_val[0]), 256'h0);
        chk("addr31_nomask", g_out[1], 256'h80000000);

        step(0, 0, 1, 2, 1, 5);
        chk("dual_out", g_out[0], 256'h24);
        chk("dual_sel", g_sel[0], 256'h20);
        chk("dual_conf", 256'(o_conf[0]), 256'h0);

        step(0, 0, 1, 7, 1, 7);
        chk("conf_out", g_out[0], 256'h80);
        chk("conf_sel_p1", g_sel[0], 256'h80);
        chk("conf_flag", 256'(o_conf[0]), 256'h1);
        chk("conf_sel_p0", g_sel[2], 256'h0);
        chk("conf_out_p0", g_out[2], 256'h80);

        step(0, 0, 1, 31, 1, 31);
        chk("zero_conf_out", g_out[0], 256'h0);
        chk("zero_conf_flag", 256'(o_conf[0]), 256'h0);
        chk("nomask_conf_flag", 256'(o_conf[1]), 256'h1);

        step(0, 0, 0, 13, 0, 22);
        chk("en_low_out", g_out[0], 256'h0);
        chk("en_low_valid", 256'(o_val[0]), 256'h0);

        step(0, 0, 1, 4, 0, 0);
        chk("stall_load", g_out[0], 256'h10);
        for (int k = 0; k < 3; k++) begin
            step(0, 1, 1, 9, 0, 0);
            chk("stall_hold", g_out[0], 256'h10);
        end
        step(0, 0, 1, 9, 0, 0);
        chk("stall_release", g_out[0], 256'h200);

        step(1, 1, 1, 6, 0, 0);
        chk("rst_over_stall", g_out[0], 256'h0);

        for (int n = 0; n < 2000; n++) begin
            int a0;
            int a1;
            a0 = $urandom_range(0, 255);
            a1 = ($urandom_range(0, 3) == 0) ? a0 : $urandom_range(0, 255);
            step($urandom_range(0, 99) < 3, $urandom_range(0, 99) < 20,
                 $urandom_range(0, 3) != 0, a0, $urandom_range(0, 3) != 0, a1);
        end

        @(negedge clk);
        @(posedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout got no finish want finish");
        $fatal(1, "timeout");
    end

endmodule
